// File: rtl/keycode_event_pio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keycode_pio_pkg : register map, bit positions and read-word helper   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package keycode_pio_pkg;

  localparam int c_bus_width  = 32;
  localparam int c_addr_width = 3;

  typedef enum logic [c_addr_width-1:0] {
    ADDR_DATA   = 3'd0,
    ADDR_MASK   = 3'd1,
    ADDR_EDGE   = 3'd2,
    ADDR_FIFO   = 3'd3,
    ADDR_STATUS = 3'd4
  } reg_addr_e;

  localparam int c_mask_ne_bit   = 0;
  localparam int c_mask_ovf_bit  = 1;
  localparam int c_mask_edge_bit = 2;

  localparam int c_stat_empty_bit = 0;
  localparam int c_stat_full_bit  = 1;
  localparam int c_stat_ovf_bit   = 2;
  localparam int c_stat_count_lsb = 8;

  localparam int c_fifo_count_lsb = 16;
  localparam int c_fifo_valid_bit = 31;
  localparam int c_count_field_w  = 5;

  function automatic logic [c_bus_width-1:0] fifo_word(
    input logic [15:0]                head,
    input logic [c_count_field_w-1:0] count,
    input logic                       nonempty
  );
    logic [c_bus_width-1:0] w;
    w = '0;
    w[15:0] = head;
    w[c_fifo_count_lsb +: c_count_field_w] = count;
    w[c_fifo_valid_bit] = nonempty;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keycode_event_pio_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keycode_event_pio_if : Avalon-MM slave bus bundle                    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface keycode_event_pio_if;
  import keycode_pio_pkg::*;

  logic [c_addr_width-1:0] address;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [c_bus_width-1:0]  writedata;
  logic [c_bus_width-1:0]  readdata;

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata
  );
endinterface
`default_nettype wire

// File: rtl/keycode_event_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keycode_event_fifo : synchronous keycode event FIFO                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module keycode_event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     reset_n,
  input  wire logic                     push,
  input  wire logic [WIDTH-1:0]         din,
  input  wire logic                     pop,
  output logic      [WIDTH-1:0]         head,
  output logic      [$clog2(DEPTH):0]   count,
  output logic                          empty,
  output logic                          full
);
  localparam int c_ptr_w = $clog2(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign empty = (r_count == '0);
  assign full  = (r_count == (c_ptr_w+1)'(DEPTH));
  assign count = r_count;
  assign head  = empty ? '0 : r_mem[r_rd_ptr];

  // A pop frees the slot this cycle, so a push into a full FIFO is accepted
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end
endmodule
`default_nettype wire

// File: rtl/keycode_event_pio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keycode_event_pio : keycode input PIO with edge capture, event FIFO  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module keycode_event_pio
  import keycode_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  keycode_event_pio_if.slave    bus,
  input  wire logic [WIDTH-1:0] in_port,
  output logic                  irq
);
  localparam int c_cnt_w = $clog2(DEPTH) + 1;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]       r_prev;
  logic [WIDTH-1:0]       r_edge;
  logic [2:0]             r_mask;
  logic                   r_ovf;
  logic [c_bus_width-1:0] r_readdata;

  logic [WIDTH-1:0]       w_val;
  logic                   w_evt;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_bus_wr;
  logic                   w_bus_rd;
  logic                   w_ovf_set;
  logic                   w_ovf_clr;
  logic [WIDTH-1:0]       w_edge_clr;
  logic [WIDTH-1:0]       w_head;
  logic [c_cnt_w-1:0]     w_count;
  logic                   w_empty;
  logic                   w_full;
  logic [c_bus_width-1:0] w_rdata;
  logic                   w_unused_ok;

  assign w_val    = r_sync[SYNC_STAGES-1];
  assign w_evt    = (w_val != r_prev);
  assign w_push   = w_evt & (|w_val);
  assign w_bus_wr = bus.chipselect & bus.write;
  assign w_bus_rd = bus.chipselect & bus.read;
  assign w_pop    = w_bus_rd & (bus.address == ADDR_FIFO);

  assign w_ovf_set  = w_push & w_full & ~w_pop;
  assign w_ovf_clr  = w_bus_wr & (bus.address == ADDR_STATUS) & bus.writedata[c_stat_ovf_bit];
  assign w_edge_clr = (w_bus_wr && bus.address == ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;

  assign w_unused_ok = ^bus.writedata[c_bus_width-1:WIDTH];

  keycode_event_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .din     (w_val),
    .pop     (w_pop),
    .head    (w_head),
    .count   (w_count),
    .empty   (w_empty),
    .full    (w_full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
      r_prev <= w_val;
    end
  end

  // Newly captured edges are OR-ed after the clear so they survive a W1C race
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge <= '0;
      r_mask <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_edge <= (r_edge & ~w_edge_clr) | (w_val ^ r_prev);
      if (w_bus_wr && bus.address == ADDR_MASK) r_mask <= bus.writedata[2:0];
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.address)
      ADDR_DATA:   w_rdata[WIDTH-1:0] = w_val;
      ADDR_MASK:   w_rdata[2:0]       = r_mask;
      ADDR_EDGE:   w_rdata[WIDTH-1:0] = r_edge;
      ADDR_FIFO:   w_rdata = fifo_word(16'(w_head), c_count_field_w'(w_count), ~w_empty);
      ADDR_STATUS: begin
        w_rdata[c_stat_empty_bit] = w_empty;
        w_rdata[c_stat_full_bit]  = w_full;
        w_rdata[c_stat_ovf_bit]   = r_ovf;
        w_rdata[c_stat_count_lsb +: c_count_field_w] = c_count_field_w'(w_count);
      end
      default:     w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_readdata <= '0;
    else          r_readdata <= w_rdata;
  end

  assign bus.readdata = r_readdata;

  assign irq = (r_mask[c_mask_ne_bit]   & ~w_empty)
             | (r_mask[c_mask_ovf_bit]  & r_ovf)
             | (r_mask[c_mask_edge_bit] & (|r_edge));
endmodule
`default_nettype wire

// File: tb/tb_keycode_event_pio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_keycode_event_pio : self-checking bench with reference model      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_keycode_event_pio;
  import keycode_pio_pkg::*;

  localparam int WIDTH       = 8;
  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 2;

  logic             clk     = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] in_port = '0;
  logic             irq;

  keycode_event_pio_if bus();

  keycode_event_pio #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of pending codes plus sticky flags
  int unsigned      q[$];
  logic [WIDTH-1:0] m_val;
  logic [WIDTH-1:0] m_edge;
  logic [2:0]       m_mask;
  bit               m_ovf;

  function automatic void model_reset();
    q.delete();
    m_val  = '0;
    m_edge = '0;
    m_mask = '0;
    m_ovf  = 1'b0;
  endfunction

  function automatic void model_code(input logic [WIDTH-1:0] v);
    if (v != m_val) begin
      m_edge = m_edge | (v ^ m_val);
      if (v != 0) begin
        if (q.size() < DEPTH) q.push_back(int'(v));
        else m_ovf = 1'b1;
      end
      m_val = v;
    end
  endfunction

  function automatic void model_pop();
    if (q.size() > 0) void'(q.pop_front());
  endfunction

  function automatic logic [31:0] exp_status();
    int n;
    n = q.size();
    return (32'(n) << 8) | (m_ovf ? 32'h4 : 32'h0) |
           ((n == DEPTH) ? 32'h2 : 32'h0) | ((n == 0) ? 32'h1 : 32'h0);
  endfunction

  function automatic logic [31:0] exp_fifo_word();
    if (q.size() == 0) return 32'h0;
    return 32'h8000_0000 | (32'(q.size()) << 16) | 32'(q[0]);
  endfunction

  function automatic logic exp_irq();
    return (m_mask[0] && q.size() != 0) || (m_mask[1] && m_ovf) || (m_mask[2] && m_edge != 0);
  endfunction

  function automatic logic [WIDTH-1:0] new_code();
    logic [WIDTH-1:0] v;
    v = WIDTH'($urandom_range(1, 255));
    if (v == m_val) v = v + 8'd1;
    if (v == 0) v = 8'd1;
    return v;
  endfunction

  task automatic bus_idle();
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.writedata  = '0;
  endtask

  task automatic set_code(input logic [WIDTH-1:0] v);
    @(negedge clk);
    in_port = v;
    model_code(v);
    repeat (4) @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.chipselect = 1'b1; bus.write = 1'b1; bus.writedata = d;
    @(negedge clk);
    bus_idle();
    case (a)
      3'd1: m_mask = d[2:0];
      3'd2: m_edge = m_edge & ~d[WIDTH-1:0];
      3'd4: if (d[2]) m_ovf = 1'b0;
      default: ;
    endcase
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] rd);
    @(negedge clk);
    bus.address = a; bus.chipselect = 1'b1; bus.read = 1'b1;
    @(negedge clk);
    rd = bus.readdata;
    bus_idle();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    in_port = '0;
    bus_idle();
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    apply_reset();
    bus_write(3'd1, 32'h7);
    set_code(8'h31);
    set_code(8'h47);
    @(negedge clk);
    in_port = 8'h5A;
    @(posedge clk);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.readdata !== 32'h0) begin
      errors++; $display("FAIL reset_readdata: got %h expected %h", bus.readdata, 32'h0);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL reset_irq: got %b expected 0", irq);
    end
    bus.address = 3'd4;
    @(negedge clk);
    in_port = 8'h1C;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    rd = bus.readdata;
    checks++;
    if (rd !== 32'h001) begin
      errors++; $display("FAIL reset_status: got %h expected %h", rd, 32'h001);
    end
    @(posedge clk); @(posedge clk); #1;
    rd = bus.readdata;
    checks++;
    if (rd !== 32'h001) begin
      errors++; $display("FAIL release_edge3_before: got %h expected %h", rd, 32'h001);
    end
    @(posedge clk); #1;
    model_code(8'h1C);
    rd = bus.readdata;
    checks++;
    if (rd !== 32'h100 || rd !== exp_status()) begin
      errors++; $display("FAIL release_push_count: got %h expected %h", rd, 32'h100);
    end
    checks++;
    if (irq !== exp_irq()) begin
      errors++; $display("FAIL release_irq: got %b expected %b", irq, exp_irq());
    end
    @(negedge clk);
    bus_idle();
  endtask

  task automatic test_press_release();
    logic [31:0] rd;
    apply_reset();
    bus_write(3'd1, 32'h1);
    set_code(8'h04);
    set_code(8'h00);
    bus_read(3'd4, rd);
    checks++;
    if (rd !== exp_status()) begin
      errors++; $display("FAIL press_status: got %h expected %h", rd, exp_status());
    end
    bus_read(3'd2, rd);
    checks++;
    if (rd !== 32'h04) begin
      errors++; $display("FAIL press_edge: got %h expected %h", rd, 32'h04);
    end
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL press_irq_high: got %b expected 1", irq);
    end
    bus_read(3'd3, rd);
    model_pop();
    checks++;
    if (rd !== 32'h8001_0004) begin
      errors++; $display("FAIL press_fifo_word: got %h expected %h", rd, 32'h8001_0004);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL press_irq_drop: got %b expected 0", irq);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    logic [31:0] exp;
    logic [WIDTH-1:0] codes [5];
    codes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    apply_reset();
    for (int i = 0; i < 5; i++) set_code(codes[i]);
    bus_read(3'd4, rd);
    checks++;
    if (rd !== 32'h406) begin
      errors++; $display("FAIL ovf_status: got %h expected %h", rd, 32'h406);
    end
    bus_write(3'd4, 32'h4);
    bus_read(3'd4, rd);
    checks++;
    if (rd !== 32'h402) begin
      errors++; $display("FAIL ovf_clear: got %h expected %h", rd, 32'h402);
    end
    for (int i = 0; i < DEPTH; i++) begin
      exp = exp_fifo_word();
      bus_read(3'd3, rd);
      model_pop();
      checks++;
      if (rd !== exp) begin
        errors++; $display("FAIL ovf_drain%0d: got %h expected %h", i, rd, exp);
      end
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] rd;
    logic [31:0] exp;
    logic [WIDTH-1:0] v;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) set_code(new_code());
    for (int k = 0; k < 6; k++) begin
      v = new_code();
      @(negedge clk);
      in_port = v;
      repeat (2) @(negedge clk);
      bus.address = 3'd3; bus.chipselect = 1'b1; bus.read = 1'b1;
      exp = exp_fifo_word();
      @(negedge clk);
      rd = bus.readdata;
      bus_idle();
      model_pop();
      model_code(v);
      checks++;
      if (rd !== exp) begin
        errors++; $display("FAIL fullpp_word%0d: got %h expected %h", k, rd, exp);
      end
      repeat (2) @(negedge clk);
    end
    bus_read(3'd4, rd);
    checks++;
    if (rd !== 32'h402 || rd !== exp_status()) begin
      errors++; $display("FAIL fullpp_status: got %h expected %h", rd, 32'h402);
    end
    for (int i = 0; i < DEPTH; i++) begin
      exp = exp_fifo_word();
      bus_read(3'd3, rd);
      model_pop();
      checks++;
      if (rd !== exp) begin
        errors++; $display("FAIL fullpp_drain%0d: got %h expected %h", i, rd, exp);
      end
    end
  endtask

  task automatic test_edge_race();
    logic [31:0] rd;
    apply_reset();
    set_code(8'h05);
    @(negedge clk);
    in_port = 8'h07;
    repeat (2) @(negedge clk);
    bus.address = 3'd2; bus.chipselect = 1'b1; bus.write = 1'b1; bus.writedata = 32'hFF;
    @(negedge clk);
    bus_idle();
    m_edge = m_edge & ~8'hFF;
    model_code(8'h07);
    bus_read(3'd2, rd);
    checks++;
    if (rd !== 32'h02 || rd !== 32'(m_edge)) begin
      errors++; $display("FAIL edge_race: got %h expected %h", rd, 32'h02);
    end
  endtask

  task automatic test_empty_read_mask();
    logic [31:0] rd;
    apply_reset();
    bus_read(3'd3, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL empty_read: got %h expected %h", rd, 32'h0);
    end
    bus_read(3'd4, rd);
    checks++;
    if (rd !== 32'h001) begin
      errors++; $display("FAIL empty_status: got %h expected %h", rd, 32'h001);
    end
    set_code(8'h2B);
    bus_read(3'd3, rd);
    model_pop();
    checks++;
    if (rd !== 32'h8001_002B) begin
      errors++; $display("FAIL empty_then_push: got %h expected %h", rd, 32'h8001_002B);
    end
    set_code(8'h3C);
    set_code(8'h3D);
    bus_write(3'd1, 32'h0);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL mask_off_irq: got %b expected 0", irq);
    end
    bus_write(3'd1, 32'h4);
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL mask_edge_irq: got %b expected 1", irq);
    end
    bus_write(3'd2, 32'hFF);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL mask_edge_cleared: got %b expected 0", irq);
    end
    bus_write(3'd1, 32'h1);
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL mask_ne_irq: got %b expected 1", irq);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [31:0] exp;
    logic [31:0] d;
    logic [2:0]  a;
    int          op;
    apply_reset();
    for (int n = 0; n < 200; n++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 3) begin
        case ($urandom_range(0, 3))
          0:       set_code('0);
          1:       set_code(m_val);
          default: set_code(WIDTH'($urandom_range(0, 255)));
        endcase
      end else if (op <= 6) begin
        a = 3'($urandom_range(0, 7));
        case (a)
          3'd0:    exp = 32'(m_val);
          3'd1:    exp = 32'(m_mask);
          3'd2:    exp = 32'(m_edge);
          3'd3:    exp = exp_fifo_word();
          3'd4:    exp = exp_status();
          default: exp = 32'h0;
        endcase
        bus_read(a, rd);
        if (a == 3'd3) model_pop();
        checks++;
        if (rd !== exp) begin
          errors++; $display("FAIL rand_read%0d addr%0d: got %h expected %h", n, a, rd, exp);
        end
      end else begin
        a = 3'($urandom_range(0, 7));
        d = $urandom;
        bus_write(a, d);
      end
      checks++;
      if (irq !== exp_irq()) begin
        errors++; $display("FAIL rand_irq%0d: got %b expected %b", n, irq, exp_irq());
      end
    end
  endtask

  initial begin
    bus_idle();
    model_reset();
    test_reset();
    test_press_release();
    test_overflow();
    test_full_push_pop();
    test_edge_race();
    test_empty_read_mask();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
